// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler that gives N_REQ requesters turns on one byte-level I2C master engine.
// Each grant runs START,{dev,W},reg,data,STOP. `define I2C_SCHED_RETRY_EN adds NACK retries.
module i2c_txn_scheduler #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 60000,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_dev,
  input  logic [8*N_REQ-1:0] req_reg,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               st_nack,
  output logic               st_tout,
  output logic               busy,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_start,
  output logic               cmd_stop,
  output logic [7:0]         cmd_byte,
  input  logic               rsp_valid,
  input  logic               rsp_nack
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_W, REG, REG_W, DATA, DATA_W, FIN} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    last, last_nx, pick_idx;
  logic             pick_found;
  int               arb_idx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [6:0]       dev_q, dev_nx;
  logic [7:0]       reg_q, reg_nx, data_q, data_nx;
  logic [N_REQ-1:0] gnt_nx, done_nx;
  logic             st_nack_nx, st_tout_nx;
  logic             cmd_valid_nx, cmd_start_nx, cmd_stop_nx;
  logic [7:0]       cmd_byte_nx;
`ifdef I2C_SCHED_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0]    retry, retry_nx;
`endif

  assign busy = |gnt;

  // Search starts one past the last winner so a just-served requester goes to the back.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    arb_idx    = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      arb_idx = (int'(last) + off) % N_REQ;
      if (!pick_found && req[arb_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(arb_idx);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets its default before the case so no latch can be inferred.
    state_nx     = state;
    last_nx      = last;
    cnt_nx       = '0;
    dev_nx       = dev_q;
    reg_nx       = reg_q;
    data_nx      = data_q;
    gnt_nx       = gnt;
    done_nx      = '0;
    st_nack_nx   = 1'b0;
    st_tout_nx   = 1'b0;
    cmd_valid_nx = cmd_valid;
    cmd_start_nx = cmd_start;
    cmd_stop_nx  = cmd_stop;
    cmd_byte_nx  = cmd_byte;
`ifdef I2C_SCHED_RETRY_EN
    retry_nx     = retry;
`endif
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_nx   = N_REQ'(1) << pick_idx;
          last_nx  = pick_idx;
          dev_nx   = req_dev[pick_idx*7 +: 7];
          reg_nx   = req_reg[pick_idx*8 +: 8];
          data_nx  = req_data[pick_idx*8 +: 8];
          state_nx = ADDR;
`ifdef I2C_SCHED_RETRY_EN
          retry_nx = '0;
`endif
        end
      end
      ADDR, REG, DATA: begin
        if (!cmd_valid) begin
          cmd_valid_nx = 1'b1;
          cmd_start_nx = (state == ADDR);
          cmd_stop_nx  = (state == DATA);
          cmd_byte_nx  = (state == ADDR) ? {dev_q, 1'b0} : (state == REG) ? reg_q : data_q;
        end else if (cmd_ready) begin
          cmd_valid_nx = 1'b0;
          cmd_start_nx = 1'b0;
          cmd_stop_nx  = 1'b0;
          cmd_byte_nx  = '0;
          state_nx     = (state == ADDR) ? ADDR_W : (state == REG) ? REG_W : DATA_W;
        end
      end
      ADDR_W, REG_W, DATA_W: begin
        cnt_nx = cnt + 1'b1;
        // A response arriving on the terminal-count cycle still counts as a response.
        if (rsp_valid && !rsp_nack) begin
          if (state == DATA_W) begin
            done_nx  = gnt;
            state_nx = FIN;
          end else begin
            state_nx = (state == ADDR_W) ? REG : DATA;
          end
        end else if (rsp_valid) begin
`ifdef I2C_SCHED_RETRY_EN
          if (retry < RW'(MAX_RETRY)) begin
            retry_nx = retry + 1'b1;
            state_nx = ADDR;
          end else begin
            st_nack_nx = 1'b1;
            done_nx    = gnt;
            state_nx   = FIN;
          end
`else
          st_nack_nx = 1'b1;
          done_nx    = gnt;
          state_nx   = FIN;
`endif
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          st_tout_nx = 1'b1;
          done_nx    = gnt;
          state_nx   = FIN;
        end
      end
      FIN: begin
        gnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and the latched request
  // fields are reset along with the FSM so every output is defined straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= IW'(N_REQ - 1);
      cnt       <= '0;
      dev_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      gnt       <= '0;
      done      <= '0;
      st_nack   <= 1'b0;
      st_tout   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
      cmd_byte  <= '0;
`ifdef I2C_SCHED_RETRY_EN
      retry     <= '0;
`endif
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      cnt       <= cnt_nx;
      dev_q     <= dev_nx;
      reg_q     <= reg_nx;
      data_q    <= data_nx;
      gnt       <= gnt_nx;
      done      <= done_nx;
      st_nack   <= st_nack_nx;
      st_tout   <= st_tout_nx;
      cmd_valid <= cmd_valid_nx;
      cmd_start <= cmd_start_nx;
      cmd_stop  <= cmd_stop_nx;
      cmd_byte  <= cmd_byte_nx;
`ifdef I2C_SCHED_RETRY_EN
      retry     <= retry_nx;
`endif
    end
  end
endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Bench for i2c_txn_scheduler: randomised engine handshake and request data against a
// transaction-level model of arbitration, byte sequence and completion status.
module tb_i2c_txn_scheduler;
  localparam int N         = 2;
  localparam int TOUT      = 16;
  localparam int MAX_RETRY = 3;
  localparam int PERIOD    = 10;
`ifdef I2C_SCHED_RETRY_EN
  localparam bit RETRY_BUILD = 1'b1;
`else
  localparam bit RETRY_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic       start;
    logic       stop;
    logic [7:0] b;
  } cmd_t;

  logic           clk, reset;
  logic [N-1:0]   req, gnt, done;
  logic [7*N-1:0] req_dev;
  logic [8*N-1:0] req_reg, req_data;
  logic           st_nack, st_tout, busy;
  logic           cmd_valid, cmd_ready, cmd_start, cmd_stop;
  logic [7:0]     cmd_byte;
  logic           rsp_valid, rsp_nack;

  int   n_assert, n_fail;
  int   nack_idx, hold_idx, model_last;
  bit   multi_gnt;
  time  t_done;
  cmd_t log_q[$];
  time  log_t[$];

  i2c_txn_scheduler #(.N_REQ(N), .TIMEOUT_CYC(TOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dev(req_dev), .req_reg(req_reg),
    .req_data(req_data), .gnt(gnt), .done(done), .st_nack(st_nack), .st_tout(st_tout),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_byte(cmd_byte), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack)
  );

  initial begin
    clk = 1'b0;
    forever #(PERIOD/2) clk = ~clk;
  end

  // Engine stand-in: random ready, random response delay, NACK/withhold by byte position.
  initial begin
    bit   pend, pend_nack;
    int   pend_cnt, byte_idx;
    cmd_t c;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
    pend = 1'b0; pend_nack = 1'b0; pend_cnt = 0; byte_idx = 0; multi_gnt = 1'b0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (!reset) pend = 1'b0;
      else if (pend) begin
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_nack  = pend_nack;
          pend      = 1'b0;
        end else pend_cnt--;
      end
      if (!$onehot0(gnt)) multi_gnt = 1'b1;
      cmd_ready = ($urandom_range(0, 3) != 0);
      if (reset && cmd_valid && cmd_ready) begin
        byte_idx = cmd_start ? 0 : byte_idx + 1;
        c = '{start: cmd_start, stop: cmd_stop, b: cmd_byte};
        log_q.push_back(c);
        log_t.push_back($time + PERIOD/2);
        if (byte_idx != hold_idx) begin
          pend      = 1'b1;
          pend_nack = (byte_idx == nack_idx);
          pend_cnt  = $urandom_range(0, 3);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++)
      if (mask[(model_last + k) % N]) return (model_last + k) % N;
    return 0;
  endfunction

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (|done) begin
        ok     = 1'b1;
        t_done = $time;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ":gnt"}, 32'(gnt), 0);
    check({tag, ":done"}, 32'(done), 0);
    check({tag, ":busy"}, 32'(busy), 0);
    check({tag, ":cmd_valid"}, 32'(cmd_valid), 0);
    check({tag, ":cmd_start"}, 32'(cmd_start), 0);
    check({tag, ":cmd_stop"}, 32'(cmd_stop), 0);
    check({tag, ":cmd_byte"}, 32'(cmd_byte), 0);
    check({tag, ":st_nack"}, 32'(st_nack), 0);
    check({tag, ":st_tout"}, 32'(st_tout), 0);
  endtask

  // Expected bytes: ADDR,REG,DATA up to the NACKed or withheld byte, repeated per attempt.
  task automatic expect_txn(input string tag, input int who, input logic [N-1:0] rel);
    cmd_t         seq[3];
    cmd_t         exp_q[$];
    int           attempts, upto;
    bit           ok;
    logic [N-1:0] who_oh;
    who_oh      = '0;
    who_oh[who] = 1'b1;
    seq[0] = '{start: 1'b1, stop: 1'b0, b: {req_dev[who*7 +: 7], 1'b0}};
    seq[1] = '{start: 1'b0, stop: 1'b0, b: req_reg[who*8 +: 8]};
    seq[2] = '{start: 1'b0, stop: 1'b1, b: req_data[who*8 +: 8]};
    attempts = (nack_idx >= 0 && RETRY_BUILD) ? MAX_RETRY + 1 : 1;
    upto     = (nack_idx >= 0) ? nack_idx : (hold_idx >= 0) ? hold_idx : 2;
    for (int a = 0; a < attempts; a++)
      for (int b = 0; b <= upto; b++) exp_q.push_back(seq[b]);
    wait_done(ok);
    check({tag, ":done_seen"}, 32'(ok), 1);
    if (ok) begin
      check({tag, ":done"}, 32'(done), 32'(who_oh));
      check({tag, ":gnt"}, 32'(gnt), 32'(who_oh));
      check({tag, ":busy"}, 32'(busy), 1);
      check({tag, ":st_nack"}, 32'(st_nack), 32'(nack_idx >= 0));
      check({tag, ":st_tout"}, 32'(st_tout), 32'(nack_idx < 0 && hold_idx >= 0));
      check({tag, ":n_bytes"}, 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
        check($sformatf("%s:byte%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
      req = req & ~rel;
      @(negedge clk);
      check({tag, ":done_after"}, 32'(done), 0);
      check({tag, ":gnt_after"}, 32'(gnt), 0);
      check({tag, ":busy_after"}, 32'(busy), 0);
    end
  endtask

  initial begin
    int           who;
    bit           ok;
    logic [N-1:0] mask;
    n_assert = 0; n_fail = 0;
    reset = 1'b0; req = '0; req_dev = '0; req_reg = '0; req_data = '0;
    nack_idx = -1; hold_idx = -1; model_last = N - 1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single requester, all bytes ACKed, plus grant / first-command latency.
    req_dev[6:0] = 7'h50; req_reg[7:0] = 8'h10; req_data[7:0] = 8'hA5;
    log_q.delete(); log_t.delete();
    req = 2'b01;
    @(negedge clk);
    check("lat:gnt", 32'(gnt), 1);
    check("lat:cmd_valid_early", 32'(cmd_valid), 0);
    @(negedge clk);
    check("lat:cmd_valid", 32'(cmd_valid), 1);
    check("lat:cmd_start", 32'(cmd_start), 1);
    check("lat:cmd_byte", 32'(cmd_byte), 32'h A0);
    who = model_pick(2'b01); model_last = who;
    expect_txn("single", who, 2'b01);

    // Both held for three transactions from a fresh pointer.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; model_last = N - 1;
    req_dev = 14'($urandom); req_reg = 16'($urandom); req_data = 16'($urandom);
    log_q.delete(); log_t.delete();
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      who = model_pick(req); model_last = who;
      expect_txn($sformatf("rr%0d", t), who, (t == 2) ? 2'b11 : 2'b00);
      log_q.delete(); log_t.delete();
    end

    // Address NACK; the requester drops req mid-transaction.
    nack_idx = 0;
    req = 2'b01;
    who = model_pick(req); model_last = who;
    repeat (2) @(negedge clk);
    req[0] = 1'b0;
    expect_txn("nack_addr", who, 2'b00);

    // Randomised transactions.
    for (int t = 0; t < 6; t++) begin
      req_dev = 14'($urandom); req_reg = 16'($urandom); req_data = 16'($urandom);
      nack_idx = int'($urandom_range(0, 4)) - 2;
      if (nack_idx < 0) nack_idx = -1;
      mask = N'($urandom_range(1, 3));
      log_q.delete(); log_t.delete();
      req = mask;
      who = model_pick(mask); model_last = who;
      expect_txn($sformatf("rand%0d", t), who, 2'b11);
    end

    // Response withheld after the REG byte, then a normal transaction.
    nack_idx = -1; hold_idx = 1;
    log_q.delete(); log_t.delete();
    req = 2'b01;
    who = model_pick(req); model_last = who;
    expect_txn("tout", who, 2'b11);
    check("tout:latency", (log_t.size() > 1) ? 32'((t_done - PERIOD/2) - log_t[1]) : 32'd0,
          32'(TOUT * PERIOD));
    hold_idx = -1;
    log_q.delete(); log_t.delete();
    req = 2'b10;
    who = model_pick(req); model_last = who;
    expect_txn("after_tout", who, 2'b11);

    // Reset while waiting on the DATA byte response.
    hold_idx = 2;
    log_q.delete(); log_t.delete();
    req = 2'b11;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (log_q.size() >= 3) begin ok = 1'b1; break; end
    end
    check("rst_mid:data_sent", 32'(ok), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    hold_idx = -1; model_last = N - 1;
    log_q.delete(); log_t.delete();
    @(negedge clk);
    reset = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (|gnt) begin ok = 1'b1; break; end
    end
    who = model_pick(req); model_last = who;
    check("rst_mid:gnt_seen", 32'(ok), 1);
    check("rst_mid:first_gnt", 32'(gnt), 32'(1 << who));
    expect_txn("rst_mid", who, 2'b11);

    check("gnt_onehot", 32'(multi_gnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
